// File: rtl/pipe_butterfly.sv
// Three-stage pipelined radix-2 butterfly: y1 = x1 + W*x2, y2 = x1 - W*x2,
// with a rounded twiddle rotation, optional halving and saturating outputs.
module pipe_butterfly #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] re_i1,
    input  logic signed [DATA_W-1:0] im_i1,
    input  logic signed [DATA_W-1:0] re_i2,
    input  logic signed [DATA_W-1:0] im_i2,
    input  logic signed [TW_W-1:0]   cos_i,
    input  logic signed [TW_W-1:0]   sin_i,
    input  logic                     inv,
    input  logic                     scale,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] re_o1,
    output logic signed [DATA_W-1:0] im_o1,
    output logic signed [DATA_W-1:0] re_o2,
    output logic signed [DATA_W-1:0] im_o2,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr
);
    localparam int PW = DATA_W + TW_W + 1;
    localparam int RW = DATA_W + 2;
    localparam int AW = DATA_W + 3;
    localparam int SH = TW_W - 2;
    localparam logic signed [PW-1:0] RND  = PW'(64'sd1 <<< (TW_W - 3));
    localparam logic signed [AW-1:0] ONE  = AW'(1);
    localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    // Returns {saturated, value}; halving rounds half up before clamping.
    function automatic logic [DATA_W:0] satScale(input logic signed [AW-1:0] v,
                                                 input logic sc);
        logic signed [AW-1:0] t;
        t = sc ? ((v + ONE) >>> 1) : v;
        if (t > MAXV)
            satScale = {1'b1, MAXV[DATA_W-1:0]};
        else if (t < MINV)
            satScale = {1'b1, MINV[DATA_W-1:0]};
        else
            satScale = {1'b0, t[DATA_W-1:0]};
    endfunction

    logic adv;

    logic                     v1_q, v2_q, mValid_q;
    logic signed [PW-1:0]     prodRc_q, prodIs_q, prodIc_q, prodRs_q;
    logic signed [DATA_W-1:0] re1S1_q, im1S1_q, re1S2_q, im1S2_q;
    logic                     scaleS1_q, scaleS2_q;
    logic signed [RW-1:0]     rotRe_q, rotIm_q;
    logic signed [DATA_W-1:0] reO1_q, imO1_q, reO2_q, imO2_q;
    logic                     ovf_q, sticky_q;

    logic signed [TW_W:0]     sinExt, sinEff;
    logic signed [PW-1:0]     prodRc_d, prodIs_d, prodIc_d, prodRs_d;
    logic signed [RW-1:0]     rotRe_d, rotIm_d;
    logic signed [AW-1:0]     sumRe, sumIm, difRe, difIm;
    logic [DATA_W:0]          satRe1, satIm1, satRe2, satIm2;
    logic                     ovf_d, sticky_d;

    assign adv     = !mValid_q | m_ready;
    assign s_ready = adv;

    // Inverse mode conjugates W by negating sin one bit wider, so -(-2^(TW_W-1)) is safe.
    always_comb begin
        sinExt   = {sin_i[TW_W-1], sin_i};
        sinEff   = inv ? -sinExt : sinExt;
        prodRc_d = PW'(re_i2) * PW'(cos_i);
        prodIs_d = PW'(im_i2) * PW'(sinEff);
        prodIc_d = PW'(im_i2) * PW'(cos_i);
        prodRs_d = PW'(re_i2) * PW'(sinEff);
    end

    always_comb begin
        rotRe_d = RW'((prodRc_q - prodIs_q + RND) >>> SH);
        rotIm_d = RW'((prodIc_q + prodRs_q + RND) >>> SH);
    end

    always_comb begin
        sumRe  = AW'(re1S2_q) + AW'(rotRe_q);
        sumIm  = AW'(im1S2_q) + AW'(rotIm_q);
        difRe  = AW'(re1S2_q) - AW'(rotRe_q);
        difIm  = AW'(im1S2_q) - AW'(rotIm_q);
        satRe1 = satScale(sumRe, scaleS2_q);
        satIm1 = satScale(sumIm, scaleS2_q);
        satRe2 = satScale(difRe, scaleS2_q);
        satIm2 = satScale(difIm, scaleS2_q);
        ovf_d  = satRe1[DATA_W] | satIm1[DATA_W] | satRe2[DATA_W] | satIm2[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            mValid_q  <= 1'b0;
            prodRc_q  <= '0;
            prodIs_q  <= '0;
            prodIc_q  <= '0;
            prodRs_q  <= '0;
            re1S1_q   <= '0;
            im1S1_q   <= '0;
            scaleS1_q <= 1'b0;
            rotRe_q   <= '0;
            rotIm_q   <= '0;
            re1S2_q   <= '0;
            im1S2_q   <= '0;
            scaleS2_q <= 1'b0;
            reO1_q    <= '0;
            imO1_q    <= '0;
            reO2_q    <= '0;
            imO2_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (adv) begin
            v1_q      <= s_valid;
            prodRc_q  <= prodRc_d;
            prodIs_q  <= prodIs_d;
            prodIc_q  <= prodIc_d;
            prodRs_q  <= prodRs_d;
            re1S1_q   <= re_i1;
            im1S1_q   <= im_i1;
            scaleS1_q <= scale;
            v2_q      <= v1_q;
            rotRe_q   <= rotRe_d;
            rotIm_q   <= rotIm_d;
            re1S2_q   <= re1S1_q;
            im1S2_q   <= im1S1_q;
            scaleS2_q <= scaleS1_q;
            mValid_q  <= v2_q;
            reO1_q    <= satRe1[DATA_W-1:0];
            imO1_q    <= satIm1[DATA_W-1:0];
            reO2_q    <= satRe2[DATA_W-1:0];
            imO2_q    <= satIm2[DATA_W-1:0];
            ovf_q     <= ovf_d;
        end
    end

    // A saturated output leaving the block takes priority over a clear.
    always_comb begin
        sticky_d = sticky_q;
        if (mValid_q && m_ready && ovf_q)
            sticky_d = 1'b1;
        else if (ovf_clr)
            sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sticky_q <= 1'b0;
        else
            sticky_q <= sticky_d;
    end

    assign m_valid    = mValid_q;
    assign re_o1      = reO1_q;
    assign im_o1      = imO1_q;
    assign re_o2      = reO2_q;
    assign im_o2      = imO2_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_pipe_butterfly.sv
// Scoreboard bench for pipe_butterfly: directed cases plus a randomized stream
// checked against an integer-arithmetic butterfly model.
module tb_pipe_butterfly;
    localparam int DATA_W = 16;
    localparam int TW_W   = 16;
    localparam longint UNIT = longint'(1) << (TW_W - 2);
    localparam longint HALF = longint'(1) << (TW_W - 3);
    localparam longint MAXO = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint MINO = -(longint'(1) << (DATA_W - 1));

    typedef struct {
        int re1;
        int im1;
        int re2;
        int im2;
        bit ovf;
    } expT;

    logic clk = 1'b0;
    logic rst, sValid, sReady, inv, scale, mValid, mReady, ovfSticky, ovfClr;
    logic signed [DATA_W-1:0] reI1, imI1, reI2, imI2, reO1, imO1, reO2, imO2;
    logic signed [TW_W-1:0]   cosI, sinI;

    expT expQ[$];
    int  testsRun = 0;
    int  testsFailed = 0;
    bit  randReady = 1'b0;
    bit  modelSticky = 1'b0;
    bit  prevStall = 1'b0;
    logic signed [DATA_W-1:0] prevRe1, prevIm1, prevRe2, prevIm2;

    always #5 clk = ~clk;

    pipe_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) dut (
        .clk(clk), .rst(rst), .s_valid(sValid), .s_ready(sReady),
        .re_i1(reI1), .im_i1(imI1), .re_i2(reI2), .im_i2(imI2),
        .cos_i(cosI), .sin_i(sinI), .inv(inv), .scale(scale),
        .m_valid(mValid), .m_ready(mReady),
        .re_o1(reO1), .im_o1(imO1), .re_o2(reO2), .im_o2(imO2),
        .ovf_sticky(ovfSticky), .ovf_clr(ovfClr)
    );

    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    // Butterfly from the arithmetic definition: rotate, round, add/sub, halve, clamp.
    function automatic expT refModel(input int r1, input int i1, input int r2, input int i2,
                                     input int c, input int s, input bit iv, input bit sc);
        expT    e;
        longint sr, wr, wi, tr, ti;
        longint a[4];
        sr = iv ? -longint'(s) : longint'(s);
        wr = longint'(r2) * c - longint'(i2) * sr;
        wi = longint'(i2) * c + longint'(r2) * sr;
        tr = floorDiv(wr + HALF, UNIT);
        ti = floorDiv(wi + HALF, UNIT);
        a[0] = r1 + tr;
        a[1] = i1 + ti;
        a[2] = r1 - tr;
        a[3] = i1 - ti;
        e.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc)
                a[k] = floorDiv(a[k] + 1, 2);
            if (a[k] > MAXO) begin
                a[k] = MAXO;
                e.ovf = 1'b1;
            end else if (a[k] < MINO) begin
                a[k] = MINO;
                e.ovf = 1'b1;
            end
        end
        e.re1 = int'(a[0]);
        e.im1 = int'(a[1]);
        e.re2 = int'(a[2]);
        e.im2 = int'(a[3]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int r1, input int i1, input int r2, input int i2,
                                 input int c, input int s, input bit iv, input bit sc);
        int waitCnt = 0;
        @(negedge clk);
        reI1 = DATA_W'(r1);
        imI1 = DATA_W'(i1);
        reI2 = DATA_W'(r2);
        imI2 = DATA_W'(i2);
        cosI = TW_W'(c);
        sinI = TW_W'(s);
        inv = iv;
        scale = sc;
        sValid = 1'b1;
        #1;
        while (!sReady) begin
            waitCnt++;
            if (waitCnt > 50) begin
                checkOutput("accept_timeout", 0, 1);
                sValid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        expQ.push_back(refModel(r1, i1, r2, i2, c, s, iv, sc));
    endtask

    task automatic applyRandom();
        int c, s, sel;
        sel = int'($urandom_range(7));
        if (sel == 0) begin
            case ($urandom_range(3))
                0: begin c = 16384;  s = 0;      end
                1: begin c = -16384; s = 0;      end
                2: begin c = 0;      s = 16384;  end
                default: begin c = 0; s = -16384; end
            endcase
        end else begin
            c = int'($urandom_range(23170)) - 11585;
            s = int'($urandom_range(23170)) - 11585;
        end
        applyStimulus(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                      int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                      c, s, 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sValid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int k = 0;
        while (expQ.size() != 0 && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    task automatic measureLatency(input string name);
        int lat = 0;
        do begin
            @(negedge clk);
            sValid = 1'b0;
            #1;
            lat++;
        end while (!mValid && lat < 10);
        checkOutput(name, lat, 3);
    endtask

    // Random downstream readiness and occasional sticky clears during the stream.
    always @(negedge clk) begin
        if (randReady) begin
            mReady = ($urandom_range(3) != 0);
            ovfClr = ($urandom_range(15) == 0);
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks stall behaviour.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prevStall = 1'b0;
            modelSticky = 1'b0;
        end else begin
            checkOutput("ovf_sticky", ovfSticky, modelSticky);
            if (prevStall) begin
                checkOutput("hold_valid", mValid, 1);
                checkOutput("hold_re1", reO1, prevRe1);
                checkOutput("hold_im1", imO1, prevIm1);
                checkOutput("hold_re2", reO2, prevRe2);
                checkOutput("hold_im2", imO2, prevIm2);
            end
            if (mValid && !mReady)
                checkOutput("stall_s_ready", sReady, 0);
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_output: got re1=%0d with no result pending", reO1);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    checkOutput("y1_re", reO1, e.re1);
                    checkOutput("y1_im", imO1, e.im1);
                    checkOutput("y2_re", reO2, e.re2);
                    checkOutput("y2_im", imO2, e.im2);
                    if (e.ovf)
                        modelSticky = 1'b1;
                    else if (ovfClr)
                        modelSticky = 1'b0;
                end
            end else if (ovfClr) begin
                modelSticky = 1'b0;
            end
            prevStall = mValid && !mReady;
            prevRe1 = reO1;
            prevIm1 = imO1;
            prevRe2 = reO2;
            prevIm2 = imO2;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sValid = 1'b0;
        mReady = 1'b1;
        ovfClr = 1'b0;
        inv = 1'b0;
        scale = 1'b0;
        reI1 = '0;
        imI1 = '0;
        reI2 = '0;
        imI2 = '0;
        cosI = '0;
        sinI = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_s_ready", sReady, 1);
        checkOutput("reset_m_valid", mValid, 0);
        checkOutput("reset_re_o1", reO1, 0);
        checkOutput("reset_im_o2", imO2, 0);
        checkOutput("reset_sticky", ovfSticky, 0);

        // Basic case with latency and single-cycle valid.
        applyStimulus(100, 0, 50, 0, 16384, 0, 1'b0, 1'b0);
        measureLatency("basic_latency");
        checkOutput("basic_re_o1", reO1, 150);
        checkOutput("basic_re_o2", reO2, 50);
        @(negedge clk);
        #1;
        checkOutput("basic_valid_one_cycle", mValid, 0);

        // Back-to-back mode change.
        applyStimulus(0, 0, 0, 100, 0, 16384, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 100, 0, 16384, 1'b1, 1'b0);
        idleCycles(1);
        waitDrain();

        // Saturation, halving, then clear.
        applyStimulus(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0);
        applyStimulus(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b1);
        idleCycles(1);
        waitDrain();
        idleCycles(1);
        #1;
        checkOutput("sat_sticky_set", ovfSticky, 1);
        @(negedge clk);
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        #3;
        checkOutput("sat_sticky_clr", ovfSticky, 0);

        // Backpressure: eight sets with downstream stalled for three cycles.
        fork
            begin
                for (int n = 0; n < 8; n++)
                    applyRandom();
                idleCycles(1);
            end
            begin
                repeat (4) @(negedge clk);
                mReady = 1'b0;
                repeat (3) @(negedge clk);
                mReady = 1'b1;
            end
        join
        waitDrain();

        // Reset with two samples in flight.
        applyRandom();
        applyRandom();
        @(negedge clk);
        sValid = 1'b0;
        rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            checkOutput("rst_flush_valid", mValid, 0);
        end
        applyRandom();
        measureLatency("rst_new_latency");
        idleCycles(1);
        waitDrain();

        // Randomized stream with random backpressure and gaps.
        randReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            applyRandom();
            if ($urandom_range(3) == 0)
                idleCycles(int'($urandom_range(3, 1)));
        end
        idleCycles(1);
        randReady = 1'b0;
        mReady = 1'b1;
        ovfClr = 1'b0;
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
